// File: rtl/serial_subtractor16.sv
// Multi-cycle subtractor: diff = in1 - in2 - borrow_in, one SLICE-bit slice per clock,
// built on the adder slice (a + ~b + carry, carry = ~borrow). start/busy/done handshake.
module serial_subtractor16 #(
    parameter int WIDTH = 16,
    parameter int SLICE = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic             borrow_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out,
    output logic             overflow,
    output logic             zero
);

    localparam int NSLICE = WIDTH / SLICE;
    localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t            r_state;
    state_t            w_state_next;

    logic [WIDTH-1:0]  r_a;
    logic [WIDTH-1:0]  r_b;
    logic [WIDTH-1:0]  r_acc;
    logic              r_carry;
    logic [IDXW-1:0]   r_idx;

    logic [WIDTH-1:0]  r_diff;
    logic              r_borrow_out;
    logic              r_overflow;
    logic              r_zero;

    logic [SLICE-1:0]  w_a_slice;
    logic [SLICE-1:0]  w_b_slice;
    logic [SLICE:0]    w_sum;
    logic [WIDTH-1:0]  w_acc_next;
    logic              w_last;
    logic              w_accept;

    assign w_last   = (r_idx == IDXW'(NSLICE - 1));
    assign w_accept = start && (r_state != S_RUN);

    always_comb begin
        w_a_slice = '0;
        w_b_slice = '0;
        for (int unsigned k = 0; k < NSLICE; k++) begin
            if (r_idx == IDXW'(k)) begin
                w_a_slice = r_a[k*SLICE +: SLICE];
                w_b_slice = r_b[k*SLICE +: SLICE];
            end
        end
    end

    // Adder slice with inverted subtrahend; carry-in holds the inverted borrow.
    assign w_sum = {1'b0, w_a_slice} + {1'b0, ~w_b_slice} + {{SLICE{1'b0}}, r_carry};

    always_comb begin
        w_acc_next = r_acc;
        for (int unsigned k = 0; k < NSLICE; k++) begin
            if (r_idx == IDXW'(k)) begin
                w_acc_next[k*SLICE +: SLICE] = w_sum[SLICE-1:0];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_next = S_RUN;
            S_RUN:   if (w_last) w_state_next = S_DONE;
            S_DONE:  w_state_next = start ? S_RUN : S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (r_state)
            S_RUN:   busy = 1'b1;
            S_DONE:  done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_a          <= '0;
            r_b          <= '0;
            r_acc        <= '0;
            r_carry      <= 1'b0;
            r_idx        <= '0;
            r_diff       <= '0;
            r_borrow_out <= 1'b0;
            r_overflow   <= 1'b0;
            r_zero       <= 1'b0;
        end else if (w_accept) begin
            r_a     <= in1;
            r_b     <= in2;
            r_carry <= ~borrow_in;
            r_idx   <= '0;
        end else if (r_state == S_RUN) begin
            r_acc   <= w_acc_next;
            r_carry <= w_sum[SLICE];
            r_idx   <= r_idx + IDXW'(1);
            if (w_last) begin
                r_diff       <= w_acc_next;
                r_borrow_out <= ~w_sum[SLICE];
                r_overflow   <= (r_a[WIDTH-1] != r_b[WIDTH-1]) &&
                                (w_acc_next[WIDTH-1] != r_a[WIDTH-1]);
                r_zero       <= ~|w_acc_next;
            end
        end
    end

    assign diff       = r_diff;
    assign borrow_out = r_borrow_out;
    assign overflow   = r_overflow;
    assign zero       = r_zero;

endmodule
